sprite_line_sequencer: RTL and testbench

//  Per-scanline sprite scheduler in the clk_draw domain. On each line pulse it walks sprite

---
 rtl/sprite_line_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_sprite_line_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_sequencer.sv
// sprite_line_sequencer
//   Per-scanline sprite scheduler in the clk_draw domain. Each line pulse
//   restarts a walk over sprite indices 0..NUM_SPRITES-1. Each index is held
//   for the matcher latency. For each intersecting sprite, one fetch beat is
//   issued per half-tile toward the non-stalling tile fetch pipeline.
//
// Ports
//   clk_draw, rst_draw         draw clock, synchronous active-high reset
//   line, enable               new-line pulse, scan enable (sampled at line)
//   sprite_index               index presented to the sprite matcher
//   match_valid, tile_count,   matcher results for sprite_index,
//   lb_addr                    valid MATCH_LAT cycles after an index change
//   beat_valid, beat_x,        fetch beat: half-tile index, line-buffer x
//   beat_lb_x                  (12'hFE0 while no beat is issued)
//   busy                       scan in progress (LOOKUP or EMIT)
//   line_done, overrun         1-cycle status pulses
//   sprites_drawn              sprites emitted this line, saturating at 511
module sprite_line_sequencer #(
    parameter int NUM_SPRITES = 512,
    parameter int MATCH_LAT   = 1
) (
    input  logic        clk_draw,
    input  logic        rst_draw,
    input  logic        line,
    input  logic        enable,
    output logic [8:0]  sprite_index,
    input  logic        match_valid,
    input  logic [7:0]  tile_count,
    input  logic [11:0] lb_addr,
    output logic        beat_valid,
    output logic [11:0] beat_x,
    output logic [11:0] beat_lb_x,
    output logic        busy,
    output logic        line_done,
    output logic        overrun,
    output logic [8:0]  sprites_drawn
);

    localparam logic [11:0] LB_IDLE   = 12'hFE0;
    localparam logic [8:0]  LAST_IDX  = 9'(NUM_SPRITES - 1);
    localparam logic [2:0]  WAIT_LAST = 3'(MATCH_LAT);

    typedef enum logic [1:0] {IDLE, LOOKUP, EMIT, DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  wait_cnt, wait_nxt;
    logic [8:0]  beats, beats_nxt;
    logic [8:0]  beat_k, beat_k_nxt;
    logic [11:0] lb_base, lb_base_nxt;
    logic [8:0]  index_nxt;
    logic [8:0]  drawn_nxt;
    logic        valid_nxt;
    logic [11:0] x_nxt;
    logic [11:0] lb_x_nxt;
    logic        done_nxt;
    logic        overrun_nxt;
    logic        advance;

    function automatic logic [8:0] sat_inc9(input logic [8:0] v);
        return (v == 9'h1FF) ? v : v + 9'd1;
    endfunction

    // Each half-tile is 8 pixels; the sum wraps modulo 4096 on purpose,
    // because off-screen pixels are clipped downstream.
    function automatic logic [11:0] beat_addr(input logic [11:0] base,
                                              input logic [8:0]  k);
        return base + {k, 3'b000};
    endfunction

    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        beats_nxt   = beats;
        beat_k_nxt  = beat_k;
        lb_base_nxt = lb_base;
        index_nxt   = sprite_index;
        drawn_nxt   = sprites_drawn;
        valid_nxt   = 1'b0;
        x_nxt       = 12'd0;
        lb_x_nxt    = LB_IDLE;
        done_nxt    = 1'b0;
        overrun_nxt = 1'b0;
        advance     = 1'b0;

        case (state)
            LOOKUP: begin
                if (wait_cnt == WAIT_LAST) begin
                    if (match_valid && tile_count != 8'd0) begin
                        // Beat 0 goes out on the first EMIT cycle, so it is
                        // launched from here.
                        state_nxt   = EMIT;
                        beats_nxt   = {tile_count, 1'b0};
                        beat_k_nxt  = 9'd0;
                        lb_base_nxt = lb_addr;
                        valid_nxt   = 1'b1;
                        x_nxt       = 12'd0;
                        lb_x_nxt    = lb_addr;
                        drawn_nxt   = sat_inc9(sprites_drawn);
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    wait_nxt = wait_cnt + 3'd1;
                end
            end
            EMIT: begin
                if (beat_k == beats - 9'd1) begin
                    advance = 1'b1;
                end else begin
                    beat_k_nxt = beat_k + 9'd1;
                    valid_nxt  = 1'b1;
                    x_nxt      = {3'b000, beat_k + 9'd1};
                    lb_x_nxt   = beat_addr(lb_base, beat_k + 9'd1);
                end
            end
            default: ;
        endcase

        if (advance) begin
            if (sprite_index == LAST_IDX) begin
                state_nxt = DONE;
                done_nxt  = 1'b1;
            end else begin
                state_nxt = LOOKUP;
                index_nxt = sprite_index + 9'd1;
                wait_nxt  = 3'd0;
            end
        end

        // A new line abandons whatever is in flight, including a half-sent sprite.
        if (line) begin
            overrun_nxt = (state == LOOKUP) || (state == EMIT);
            valid_nxt   = 1'b0;
            x_nxt       = 12'd0;
            lb_x_nxt    = LB_IDLE;
            done_nxt    = 1'b0;
            if (enable) begin
                state_nxt = LOOKUP;
                index_nxt = 9'd0;
                wait_nxt  = 3'd0;
                drawn_nxt = 9'd0;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk_draw) begin
        if (rst_draw) begin
            state         <= IDLE;
            wait_cnt      <= 3'd0;
            sprite_index  <= 9'd0;
            sprites_drawn <= 9'd0;
            beat_valid    <= 1'b0;
            beat_x        <= 12'd0;
            beat_lb_x     <= LB_IDLE;
            busy          <= 1'b0;
            line_done     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state         <= state_nxt;
            wait_cnt      <= wait_nxt;
            sprite_index  <= index_nxt;
            sprites_drawn <= drawn_nxt;
            beat_valid    <= valid_nxt;
            beat_x        <= x_nxt;
            beat_lb_x     <= lb_x_nxt;
            busy          <= (state_nxt == LOOKUP) || (state_nxt == EMIT);
            line_done     <= done_nxt;
            overrun       <= overrun_nxt;
        end
    end

    // Per-sprite beat bookkeeping; only read in EMIT, after LOOKUP loads it.
    always_ff @(posedge clk_draw) begin
        beats   <= beats_nxt;
        beat_k  <= beat_k_nxt;
        lb_base <= lb_base_nxt;
    end

endmodule

// File: tb/tb_sprite_line_sequencer.sv
module tb_sprite_line_sequencer;

    logic        clk_draw = 1'b0;
    logic        rst_draw = 1'b1;
    logic        line = 1'b0;
    logic        enable = 1'b1;
    logic [8:0]  sprite_index;
    logic        match_valid = 1'b0;
    logic [7:0]  tile_count = 8'd0;
    logic [11:0] lb_addr = 12'd0;
    logic        beat_valid;
    logic [11:0] beat_x;
    logic [11:0] beat_lb_x;
    logic        busy;
    logic        line_done;
    logic        overrun;
    logic [8:0]  sprites_drawn;

    int checks = 0;
    int errors = 0;

    sprite_line_sequencer #(.NUM_SPRITES(4), .MATCH_LAT(1)) dut (
        .clk_draw(clk_draw), .rst_draw(rst_draw), .line(line), .enable(enable),
        .sprite_index(sprite_index), .match_valid(match_valid),
        .tile_count(tile_count), .lb_addr(lb_addr), .beat_valid(beat_valid),
        .beat_x(beat_x), .beat_lb_x(beat_lb_x), .busy(busy),
        .line_done(line_done), .overrun(overrun), .sprites_drawn(sprites_drawn)
    );

    always #5 clk_draw = ~clk_draw;

    // Matcher model: results follow sprite_index with one cycle of latency.
    logic        m_valid [4];
    logic [7:0]  m_tc    [4];
    logic [11:0] m_lb    [4];

    always @(posedge clk_draw) begin
        match_valid <= m_valid[sprite_index[1:0]];
        tile_count  <= m_tc[sprite_index[1:0]];
        lb_addr     <= m_lb[sprite_index[1:0]];
    end

    typedef struct packed {
        logic        line;
        logic        en;
        logic        bv;
        logic [11:0] bx;
        logic [11:0] blx;
        logic        busy;
        logic        done;
        logic        ovr;
        logic [8:0]  idx;
    } vec_t;

    vec_t tv [14];

    function automatic vec_t mk(bit l, bit e, bit v, int x, int lb, bit b,
                                bit d, bit o, int i);
        vec_t r;
        r.line = l; r.en = e; r.bv = v;
        r.bx = x[11:0]; r.blx = lb[11:0];
        r.busy = b; r.done = d; r.ovr = o; r.idx = i[8:0];
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_draw);
        #1;
    endtask

    task automatic set_sprites(input bit v0, input int tc0, input int lb0,
                               input bit v1, input int tc1, input int lb1,
                               input bit v2, input int tc2, input int lb2);
        m_valid[0] = v0; m_tc[0] = tc0[7:0]; m_lb[0] = lb0[11:0];
        m_valid[1] = v1; m_tc[1] = tc1[7:0]; m_lb[1] = lb1[11:0];
        m_valid[2] = v2; m_tc[2] = tc2[7:0]; m_lb[2] = lb2[11:0];
        m_valid[3] = 1'b0; m_tc[3] = 8'd0; m_lb[3] = 12'd0;
    endtask

    task automatic pulse_line(input bit en);
        enable = en;
        line = 1'b1;
        step();
        line = 1'b0;
    endtask

    initial begin
        // Sprite 1 only: tile_count=2 at x=100. Row j shows outputs at t+1+j.
        // enable drops mid-scan from row 5 and must not disturb the scan.
        tv[0]  = mk(1, 1, 0, 0, 4064, 1, 0, 0, 0);
        tv[1]  = mk(0, 1, 0, 0, 4064, 1, 0, 0, 0);
        tv[2]  = mk(0, 1, 0, 0, 4064, 1, 0, 0, 1);
        tv[3]  = mk(0, 1, 0, 0, 4064, 1, 0, 0, 1);
        tv[4]  = mk(0, 1, 1, 0, 100,  1, 0, 0, 1);
        tv[5]  = mk(0, 0, 1, 1, 108,  1, 0, 0, 1);
        tv[6]  = mk(0, 0, 1, 2, 116,  1, 0, 0, 1);
        tv[7]  = mk(0, 0, 1, 3, 124,  1, 0, 0, 1);
        tv[8]  = mk(0, 0, 0, 0, 4064, 1, 0, 0, 2);
        tv[9]  = mk(0, 0, 0, 0, 4064, 1, 0, 0, 2);
        tv[10] = mk(0, 0, 0, 0, 4064, 1, 0, 0, 3);
        tv[11] = mk(0, 0, 0, 0, 4064, 1, 0, 0, 3);
        tv[12] = mk(0, 0, 0, 0, 4064, 0, 1, 0, 3);
        tv[13] = mk(0, 0, 0, 0, 4064, 0, 0, 0, 3);

        set_sprites(0, 0, 0, 1, 2, 100, 0, 0, 0);

        // Reset and idle
        rst_draw = 1'b1;
        step();
        step();
        rst_draw = 1'b0;
        chk("rst_beat_valid", int'(beat_valid), 0);
        chk("rst_beat_lb_x", int'(beat_lb_x), 12'hFE0);
        chk("rst_beat_x", int'(beat_x), 0);
        chk("rst_index", int'(sprite_index), 0);
        chk("rst_drawn", int'(sprites_drawn), 0);
        for (int c = 0; c < 10; c++) begin
            step();
            chk("idle_beat_valid", int'(beat_valid), 0);
            chk("idle_beat_lb_x", int'(beat_lb_x), 12'hFE0);
            chk("idle_busy", int'(busy), 0);
            chk("idle_pulses", int'({line_done, overrun}), 0);
        end

        // Table-driven scan with one matching sprite
        for (int j = 0; j < 14; j++) begin
            line = tv[j].line;
            enable = tv[j].en;
            step();
            chk($sformatf("tv%0d_beat_valid", j), int'(beat_valid), int'(tv[j].bv));
            chk($sformatf("tv%0d_beat_x", j), int'(beat_x), int'(tv[j].bx));
            chk($sformatf("tv%0d_beat_lb_x", j), int'(beat_lb_x), int'(tv[j].blx));
            chk($sformatf("tv%0d_busy", j), int'(busy), int'(tv[j].busy));
            chk($sformatf("tv%0d_line_done", j), int'(line_done), int'(tv[j].done));
            chk($sformatf("tv%0d_overrun", j), int'(overrun), int'(tv[j].ovr));
            chk($sformatf("tv%0d_index", j), int'(sprite_index), int'(tv[j].idx));
        end
        line = 1'b0;
        chk("scan1_drawn", int'(sprites_drawn), 1);

        // No sprite matches: each index held two cycles, line_done at t+9
        set_sprites(0, 0, 0, 0, 0, 0, 0, 0, 0);
        pulse_line(1'b1);
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("nomatch_index_t%0d", c), int'(sprite_index), (c - 1) / 2);
            chk("nomatch_beat_valid", int'(beat_valid), 0);
            chk("nomatch_line_done_early", int'(line_done), 0);
            chk("nomatch_overrun", int'(overrun), 0);
            step();
        end
        chk("nomatch_line_done", int'(line_done), 1);
        chk("nomatch_busy_done", int'(busy), 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("done_hold_pulse", int'(line_done), 0);
            chk("done_hold_busy", int'(busy), 0);
            chk("done_hold_index", int'(sprite_index), 3);
            chk("done_hold_beat_valid", int'(beat_valid), 0);
        end
        chk("nomatch_drawn", int'(sprites_drawn), 0);

        // Line-buffer x wraps modulo 4096
        set_sprites(1, 1, 4090, 0, 0, 0, 0, 0, 0);
        pulse_line(1'b1);
        step();
        step();
        chk("wrap_beat0_valid", int'(beat_valid), 1);
        chk("wrap_beat0_lb_x", int'(beat_lb_x), 4090);
        step();
        chk("wrap_beat1_valid", int'(beat_valid), 1);
        chk("wrap_beat1_x", int'(beat_x), 1);
        chk("wrap_beat1_lb_x", int'(beat_lb_x), 2);
        step();
        chk("wrap_after_valid", int'(beat_valid), 0);
        chk("wrap_after_lb_x", int'(beat_lb_x), 12'hFE0);
        for (int c = 0; c < 10; c++) step();
        chk("wrap_finished_busy", int'(busy), 0);

        // Line re-pulsed while sprite 2 is emitting (third beat at t+9)
        set_sprites(0, 0, 0, 0, 0, 0, 1, 4, 0);
        pulse_line(1'b1);
        for (int c = 0; c < 8; c++) step();
        chk("ovr_pre_beat_valid", int'(beat_valid), 1);
        chk("ovr_pre_beat_x", int'(beat_x), 2);
        chk("ovr_pre_lb_x", int'(beat_lb_x), 16);
        chk("ovr_pre_drawn", int'(sprites_drawn), 1);
        pulse_line(1'b1);
        chk("ovr_pulse", int'(overrun), 1);
        chk("ovr_beat_valid", int'(beat_valid), 0);
        chk("ovr_lb_x", int'(beat_lb_x), 12'hFE0);
        chk("ovr_index", int'(sprite_index), 0);
        chk("ovr_drawn", int'(sprites_drawn), 0);
        chk("ovr_busy", int'(busy), 1);
        chk("ovr_line_done", int'(line_done), 0);
        step();
        chk("ovr_pulse_end", int'(overrun), 0);
        chk("ovr_beat_valid_next", int'(beat_valid), 0);
        for (int c = 0; c < 20; c++) step();
        chk("ovr_rescan_busy", int'(busy), 0);
        chk("ovr_rescan_drawn", int'(sprites_drawn), 1);

        // enable=0 at line: IDLE, no beats, count held
        pulse_line(1'b0);
        chk("dis_busy", int'(busy), 0);
        chk("dis_overrun", int'(overrun), 0);
        chk("dis_drawn", int'(sprites_drawn), 1);
        for (int c = 0; c < 8; c++) begin
            step();
            chk("dis_beat_valid", int'(beat_valid), 0);
            chk("dis_busy_hold", int'(busy), 0);
        end

        // Reset mid-EMIT, together with a line pulse
        set_sprites(1, 3, 200, 0, 0, 0, 0, 0, 0);
        pulse_line(1'b1);
        step();
        step();
        chk("rstemit_beat0", int'(beat_valid), 1);
        step();
        chk("rstemit_beat1_lb_x", int'(beat_lb_x), 208);
        rst_draw = 1'b1;
        line = 1'b1;
        step();
        rst_draw = 1'b0;
        line = 1'b0;
        chk("rstemit_beat_valid", int'(beat_valid), 0);
        chk("rstemit_beat_x", int'(beat_x), 0);
        chk("rstemit_lb_x", int'(beat_lb_x), 12'hFE0);
        chk("rstemit_busy", int'(busy), 0);
        chk("rstemit_overrun", int'(overrun), 0);
        chk("rstemit_drawn", int'(sprites_drawn), 0);
        chk("rstemit_index", int'(sprite_index), 0);
        step();
        chk("rstemit_idle_busy", int'(busy), 0);
        chk("rstemit_idle_valid", int'(beat_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
